// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter: FSM state
// encoding, default bit period and the idle line level.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
      ST_PARITY = 3'd5,
      ST_STOP   = 3'd6
   } uart_state_t;

   // 25 MHz system clock, 115200 baud
   localparam int CLKS_PER_BIT_DEFAULT = 217;

   localparam logic UART_IDLE_LEVEL = 1'b1;

   // Even parity bit: makes the count of ones across data + parity even
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the last count
// with tick; clear restarts the period (used on every FSM state entry).
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count_r;

   // Period counter: clear has priority, wraps after the last count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {CW{1'b0}};
      end else if (clear) begin
         count_r <= {CW{1'b0}};
      end else if (count_r == LAST) begin
         count_r <= {CW{1'b0}};
      end else begin
         count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   assign tick = (count_r == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame from the byte FIFO and sends
// it LSB first on a UART line (8N1). Defining FIFO_UART_PARITY_EN inserts
// an even-parity bit between the data bits and the stop bit.
// All outputs are registered from the next-state values so they line up
// with the state they belong to.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd_en,
   output logic       tx,
   output logic       busy
);

   uart_state_t state_r;
   uart_state_t next_state_s;

   logic [7:0] shift_r;
   logic [7:0] shift_next_s;
   logic [2:0] bit_idx_r;
   logic [2:0] bit_idx_next_s;

   logic tx_r;
   logic busy_r;
   logic rd_en_r;
   logic tx_next_s;
   logic busy_next_s;
   logic rd_en_next_s;

   logic tick_s;
   logic clear_s;

`ifdef FIFO_UART_PARITY_EN
   logic parity_r;
`endif

   // Every state entry restarts the bit period
   assign clear_s = (next_state_s != state_r);

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_s),
      .tick  (tick_s)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; en and fifo_empty matter only in IDLE and at the end of STOP
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (en && !fifo_empty) begin
               next_state_s = ST_FETCH;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            next_state_s = ST_LOAD;
         end
         ST_LOAD: begin
            next_state_s = ST_START;
         end
         ST_START: begin
            if (tick_s) begin
               next_state_s = ST_DATA;
            end else begin
               next_state_s = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s && (bit_idx_r == 3'd7)) begin
`ifdef FIFO_UART_PARITY_EN
               next_state_s = ST_PARITY;
`else
               next_state_s = ST_STOP;
`endif
            end else begin
               next_state_s = ST_DATA;
            end
         end
         ST_PARITY: begin
`ifdef FIFO_UART_PARITY_EN
            if (tick_s) begin
               next_state_s = ST_STOP;
            end else begin
               next_state_s = ST_PARITY;
            end
`else
            // Unreachable without parity; recover to a safe idle line
            next_state_s = ST_IDLE;
`endif
         end
         ST_STOP: begin
            if (tick_s) begin
               if (en && !fifo_empty) begin
                  next_state_s = ST_FETCH;
               end else begin
                  next_state_s = ST_IDLE;
               end
            end else begin
               next_state_s = ST_STOP;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Shift register and bit index: load in LOAD, shift on each data-bit end
   always_comb begin
      shift_next_s   = shift_r;
      bit_idx_next_s = bit_idx_r;
      case (state_r)
         ST_LOAD: begin
            shift_next_s   = fifo_data;
            bit_idx_next_s = 3'd0;
         end
         ST_DATA: begin
            if (tick_s) begin
               shift_next_s   = {1'b0, shift_r[7:1]};
               bit_idx_next_s = bit_idx_r + 3'd1;
            end else begin
               shift_next_s   = shift_r;
               bit_idx_next_s = bit_idx_r;
            end
         end
         default: begin
            shift_next_s   = shift_r;
            bit_idx_next_s = bit_idx_r;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_r   <= 8'h00;
         bit_idx_r <= 3'd0;
      end else begin
         shift_r   <= shift_next_s;
         bit_idx_r <= bit_idx_next_s;
      end
   end

`ifdef FIFO_UART_PARITY_EN
   // Parity of the byte, captured alongside the shift register load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_r <= 1'b0;
      end else if (state_r == ST_LOAD) begin
         parity_r <= even_parity(fifo_data);
      end else begin
         parity_r <= parity_r;
      end
   end
`endif

   // Output decode from the state being entered, so registered outputs track the state
   always_comb begin
      tx_next_s    = UART_IDLE_LEVEL;
      busy_next_s  = (next_state_s != ST_IDLE);
      rd_en_next_s = (next_state_s == ST_FETCH);
      case (next_state_s)
         ST_START: begin
            tx_next_s = 1'b0;
         end
         ST_DATA: begin
            tx_next_s = shift_next_s[0];
         end
`ifdef FIFO_UART_PARITY_EN
         ST_PARITY: begin
            tx_next_s = parity_r;
         end
`endif
         default: begin
            tx_next_s = UART_IDLE_LEVEL;
         end
      endcase
   end

   // Output registers; reset forces an idle line at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_r    <= UART_IDLE_LEVEL;
         busy_r  <= 1'b0;
         rd_en_r <= 1'b0;
      end else begin
         tx_r    <= tx_next_s;
         busy_r  <= busy_next_s;
         rd_en_r <= rd_en_next_s;
      end
   end

   assign tx         = tx_r;
   assign busy       = busy_r;
   assign fifo_rd_en = rd_en_r;

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drain stage placed directly downstream of the 8-deep byte FIFO. Pops one byte at a time through the FIFO read interface (`rd_en` pulse; `data_out` valid the cycle after the pop) and serializes it on a UART line as 8N1, LSB first. Handles back-to-back frames while the FIFO is non-empty and the block is enabled. It is the only consumer of the FIFO read port.

## Interface
- `CLKS_PER_BIT`, default 217 — clock cycles per UART bit (25 MHz / 115200); legal minimum 2.
- `clk`  in  1  — system clock; all state updates on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `en`  in  1  — allows starting new frames; sampled only in IDLE and at end of STOP.
- `fifo_empty`  in  1  — FIFO `empty` flag.
- `fifo_data`  in  8  — FIFO `data_out`.
- `fifo_rd_en`  out  1  — FIFO `rd_en`; single-cycle pulse per byte.
- `tx`  out  1  — serial line, idle high; registered.
- `busy`  out  1  — high whenever state ≠ IDLE.

## Operation
- Reset values: `tx`=1, `busy`=0, `fifo_rd_en`=0, state IDLE, counters 0, shift register 0.
- FSM: IDLE, FETCH, LOAD, START, DATA, [PARITY], STOP.
- IDLE: if `en` && !`fifo_empty` → FETCH; else stay.
- FETCH (1 cycle): `fifo_rd_en`=1 → LOAD. `fifo_rd_en` is high only in FETCH.
- LOAD (1 cycle): shift register ← `fifo_data` at end of cycle → START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles → DATA.
- DATA: 8 bits, bit 0 first, each `CLKS_PER_BIT` cycles. 3-bit index wraps 7 → exit.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On its last cycle: if `en` && !`fifo_empty` → FETCH, else → IDLE.
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It is cleared on every state entry, and a bit ends when the counter reaches `CLKS_PER_BIT-1`.
- Deasserting `en` mid-frame: the current frame completes, and no new fetch occurs.
- `fifo_empty` is ignored outside IDLE and STOP-exit. At most one byte is in flight, so the block never reads an empty FIFO.
- `rst` mid-frame: `tx` goes to 1 and `busy` to 0 immediately. The in-flight byte is lost and is not re-read.

## Timing
- Decision edge E0 (IDLE or STOP-exit) → `fifo_rd_en` high in cycle E0..E1 → LOAD in E1..E2 → `tx` falls at E2.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- Back-to-back frames: exactly 2 extra idle-high cycles (FETCH, LOAD) between the end of STOP and the next start bit.
- Throughput: one FIFO pop per frame.

## Configuration
- `FIFO_UART_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
- Not defined: no PARITY state; the frame is 8N1.

## Structure
- Package `uart_pkg`: FSM state encoding (typedef), the default `CLKS_PER_BIT` localparam, and the `UART_IDLE_LEVEL`=1 constant.
- Sub-module `uart_baud_gen`: counter with `clear` input and `tick` output (one cycle at count `CLKS_PER_BIT-1`). It is instantiated once.
- The FSM, shift register and bit index live in the top module.

## Test plan
Benches use `CLKS_PER_BIT`=4 unless noted.
- Reset: assert `rst` with the FIFO holding data → `tx`=1, `busy`=0, `fifo_rd_en`=0 while reset is held.
- Single byte 0xA5, `en`=1 → one `fifo_rd_en` pulse. `tx` sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1. With `FIFO_UART_PARITY_EN`: 0,1,0,1,0,0,1,0,1,0,1.
- Bytes 0x01, 0x02, 0x03 queued → exactly 3 `rd_en` pulses, frames decode in order, 2 high cycles between a stop bit and the next start bit, `busy` continuously high.
- `fifo_empty`=1, `en`=1 for 100 cycles → `fifo_rd_en` never asserted, `tx`=1, `busy`=0.
- Drop `en` during DATA of the first of two queued bytes → first frame completes, no second `rd_en`, IDLE after STOP.
- Assert `rst` during data bit 3 → `tx`=1 asynchronously. After release with 0x3C queued, a fresh complete frame of 0x3C is sent.
